decode_writeback: RTL and testbench

- SEQ decode and write-back stage for the Y86-64 processor; sits directly downstream of fetch.
- Consumes icode/ifun/rA/rB from fetch, selects the source and destination register IDs, and reads valA/valB from a 15-entry 64-bit register file.
- Commits valE/valM back at the clock edge at the end of each instruction.
- Tracks sticky processor status (AOK/HLT/ADR/INS) and freezes architectural state once the status leaves AOK.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/decode_writeback_if.sv | 31 +++
 rtl/regfile_15x64.sv | 35 +++
 rtl/decode_writeback.sv | 55 +++++
 tb/tb_decode_writeback.sv | 127 ++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode, register and status constants.
package y86_pkg;
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RRSP    = 4'h4;
   localparam logic [3:0] RNONE   = 4'hF;
   localparam int NREGS = 15;
   typedef enum logic [2:0] {
      SAOK = 3'd1,
      SHLT = 3'd2,
      SADR = 3'd3,
      SINS = 3'd4
   } stat_t;
endpackage

// File: rtl/decode_writeback_if.sv
// decode_writeback_if: fetch/execute/memory-facing signals of the decode/write-back stage.
interface decode_writeback_if;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        instr_valid;
   logic        imem_error;
   logic        dmem_error;
   logic        cnd;
   logic [63:0] valE;
   logic [63:0] valM;
   logic        wb_en;
   logic [3:0]  dbg_addr;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [3:0]  dstE;
   logic [3:0]  dstM;
   logic [2:0]  stat;
   logic [63:0] dbg_data;
   modport master (
      output icode, ifun, rA, rB, instr_valid, imem_error, dmem_error, cnd, valE, valM, wb_en, dbg_addr,
      input  valA, valB, srcA, srcB, dstE, dstM, stat, dbg_data
   );
   modport slave (
      input  icode, ifun, rA, rB, instr_valid, imem_error, dmem_error, cnd, valE, valM, wb_en, dbg_addr,
      output valA, valB, srcA, srcB, dstE, dstM, stat, dbg_data
   );
endinterface

// File: rtl/regfile_15x64.sv
// regfile_15x64: 15x64 register file, two read ports plus debug read, two write ports with M over E.
module regfile_15x64
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_BASE = 64'h0000_0000_0000_0200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   input  logic [3:0]  dbg_addr,
   input  logic [3:0]  dst_e,
   input  logic [3:0]  dst_m,
   input  logic        we_e,
   input  logic        we_m,
   input  logic [63:0] val_e,
   input  logic [63:0] val_m,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   output logic [63:0] dbg_data
);
   logic [63:0] regs [NREGS];
   assign val_a    = (src_a == RNONE) ? '0 : regs[src_a];
   assign val_b    = (src_b == RNONE) ? '0 : regs[src_b];
   assign dbg_data = (dbg_addr == RNONE) ? '0 : regs[dbg_addr];
   // M port is written last so it wins when both target the same register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= (i == int'(RRSP)) ? STACK_BASE : '0;
      end else begin
         if (we_e && dst_e != RNONE) regs[dst_e] <= val_e;
         if (we_m && dst_m != RNONE) regs[dst_m] <= val_m;
      end
   end
endmodule

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 SEQ decode (register ID select, operand read) and write-back with sticky status.
module decode_writeback
   import y86_pkg::*;
#(
   parameter logic [63:0] STACK_BASE = 64'h0000_0000_0000_0200
) (
   input logic clk,
   input logic rst,
   decode_writeback_if.slave bus
);
   stat_t state, state_nxt;
   logic  commit;
   logic  unused_ifun;
   assign unused_ifun = ^bus.ifun;
   assign bus.srcA = (bus.icode inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) ? bus.rA :
                     (bus.icode inside {IPOPQ, IRET}) ? RRSP : RNONE;
   assign bus.srcB = (bus.icode inside {IRMMOVQ, IMRMOVQ, IOPQ}) ? bus.rB :
                     (bus.icode inside {IPUSHQ, IPOPQ, ICALL, IRET}) ? RRSP : RNONE;
   assign bus.dstE = ((bus.icode == IRRMOVQ && bus.cnd) || bus.icode inside {IIRMOVQ, IOPQ}) ? bus.rB :
                     (bus.icode inside {IPUSHQ, IPOPQ, ICALL, IRET}) ? RRSP : RNONE;
   assign bus.dstM = (bus.icode inside {IMRMOVQ, IPOPQ}) ? bus.rA : RNONE;
   always_ff @(posedge clk) begin
      if (rst) state <= SAOK;
      else     state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (state == SAOK && bus.wb_en)
         state_nxt = bus.imem_error   ? SADR :
                     !bus.instr_valid ? SINS :
                     bus.dmem_error   ? SADR :
                     (bus.icode == IHALT) ? SHLT : SAOK;
   end
   // an instruction that leaves AOK, or arrives after it was left, never writes
   always_comb begin
      bus.stat = state;
      commit   = (state == SAOK) && bus.wb_en && (state_nxt == SAOK);
   end
   regfile_15x64 #(.STACK_BASE(STACK_BASE)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .src_a    (bus.srcA),
      .src_b    (bus.srcB),
      .dbg_addr (bus.dbg_addr),
      .dst_e    (bus.dstE),
      .dst_m    (bus.dstM),
      .we_e     (commit),
      .we_m     (commit),
      .val_e    (bus.valE),
      .val_m    (bus.valM),
      .val_a    (bus.valA),
      .val_b    (bus.valB),
      .dbg_data (bus.dbg_data)
   );
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed vector table plus hand sequences for reset, sticky status and faults.
module tb_decode_writeback;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   decode_writeback_if bus ();
   decode_writeback dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic [3:0]  icode, ra, rb;
      logic        cnd, wb;
      logic [63:0] vale, valm;
      logic [3:0]  dbg;
      logic [3:0]  s_a, s_b, d_e, d_m;
      logic [63:0] va, vb, dbg_val;
      logic [2:0]  st;
   } vec_t;
   vec_t vecs [16];
   function automatic vec_t mk(logic [3:0] icode, ra, rb, logic cnd, wb, logic [63:0] vale, valm,
                               logic [3:0] dbg, s_a, s_b, d_e, d_m, logic [63:0] va, vb, dbg_val, logic [2:0] st);
      vec_t v;
      v.icode = icode; v.ra = ra; v.rb = rb; v.cnd = cnd; v.wb = wb; v.vale = vale; v.valm = valm;
      v.dbg = dbg; v.s_a = s_a; v.s_b = s_b; v.d_e = d_e; v.d_m = d_m; v.va = va; v.vb = vb;
      v.dbg_val = dbg_val; v.st = st;
      return v;
   endfunction
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(logic [3:0] icode, ra, rb, logic cnd, iv, imem, dmem, wb, logic [63:0] vale, valm);
      bus.icode = icode; bus.ifun = 4'h0; bus.rA = ra; bus.rB = rb; bus.cnd = cnd;
      bus.instr_valid = iv; bus.imem_error = imem; bus.dmem_error = dmem; bus.wb_en = wb;
      bus.valE = vale; bus.valM = valm;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask
   task automatic peek(string name, logic [3:0] id, logic [63:0] exp);
      bus.dbg_addr = id;
      #1 check(name, bus.dbg_data, exp);
   endtask
   initial begin
      vecs[0]  = mk(4'h3, 4'hF, 4'h2, 0, 1, 64'h1234, 64'h0,    4'h2, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0,    64'h0,    64'h1234, 3'd1);
      vecs[1]  = mk(4'h6, 4'h2, 4'h2, 0, 1, 64'h99,   64'h0,    4'h2, 4'h2, 4'h2, 4'h2, 4'hF, 64'h1234, 64'h1234, 64'h99,   3'd1);
      vecs[2]  = mk(4'hB, 4'h4, 4'hF, 0, 1, 64'h208,  64'hABCD, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 64'h200,  64'h200,  64'hABCD, 3'd1);
      vecs[3]  = mk(4'h3, 4'hF, 4'h1, 0, 1, 64'h77,   64'h0,    4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 64'h0,    64'h0,    64'h77,   3'd1);
      vecs[4]  = mk(4'h2, 4'h1, 4'h3, 0, 1, 64'h55,   64'h0,    4'h3, 4'h1, 4'hF, 4'hF, 4'hF, 64'h77,   64'h0,    64'h0,    3'd1);
      vecs[5]  = mk(4'h2, 4'h1, 4'h3, 1, 1, 64'h55,   64'h0,    4'h3, 4'h1, 4'hF, 4'h3, 4'hF, 64'h77,   64'h0,    64'h55,   3'd1);
      vecs[6]  = mk(4'hA, 4'h3, 4'hF, 0, 1, 64'hABC5, 64'h0,    4'h4, 4'h3, 4'h4, 4'h4, 4'hF, 64'h55,   64'hABCD, 64'hABC5, 3'd1);
      vecs[7]  = mk(4'h5, 4'h6, 4'h3, 0, 1, 64'h70,   64'h66,   4'h6, 4'hF, 4'h3, 4'hF, 4'h6, 64'h0,    64'h55,   64'h66,   3'd1);
      vecs[8]  = mk(4'h3, 4'hF, 4'h7, 0, 0, 64'h9,    64'h0,    4'h7, 4'hF, 4'hF, 4'h7, 4'hF, 64'h0,    64'h0,    64'h0,    3'd1);
      vecs[9]  = mk(4'h8, 4'hF, 4'hF, 0, 1, 64'h300,  64'h0,    4'h4, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0,    64'hABC5, 64'h300,  3'd1);
      vecs[10] = mk(4'h9, 4'hF, 4'hF, 0, 1, 64'h308,  64'h1000, 4'h4, 4'h4, 4'h4, 4'h4, 4'hF, 64'h300,  64'h300,  64'h308,  3'd1);
      vecs[11] = mk(4'h4, 4'h5, 4'h6, 0, 1, 64'h11,   64'h22,   4'h6, 4'h5, 4'h6, 4'hF, 4'hF, 64'h0,    64'h66,   64'h66,   3'd1);
      vecs[12] = mk(4'h1, 4'h2, 4'h3, 1, 1, 64'h33,   64'h44,   4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h99,   3'd1);
      vecs[13] = mk(4'h3, 4'hF, 4'hF, 0, 1, 64'h5,    64'h0,    4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h0,    3'd1);
      vecs[14] = mk(4'h0, 4'hF, 4'hF, 0, 1, 64'h0,    64'h0,    4'h4, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    64'h308,  3'd2);
      vecs[15] = mk(4'h3, 4'hF, 4'h5, 0, 1, 64'h7,    64'h0,    4'h5, 4'hF, 4'hF, 4'h5, 4'hF, 64'h0,    64'h0,    64'h0,    3'd2);
      drive(4'h1, 4'hF, 4'hF, 0, 1, 0, 0, 0, 64'h0, 64'h0);
      bus.dbg_addr = 4'h0;
      do_reset();
      check("reset_stat", 64'(bus.stat), 64'd1);
      for (int r = 0; r < 15; r++) peek($sformatf("reset_reg%0d", r), 4'(r), (r == 4) ? 64'h200 : 64'h0);
      peek("dbg_rnone", 4'hF, 64'h0);
      drive(4'h6, 4'h2, 4'h2, 0, 1, 0, 0, 0, 64'h0, 64'h0);
      #1 check("reset_valA", bus.valA, 64'h0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].icode, vecs[i].ra, vecs[i].rb, vecs[i].cnd, 1, 0, 0, vecs[i].wb, vecs[i].vale, vecs[i].valm);
         bus.dbg_addr = vecs[i].dbg;
         #1;
         check($sformatf("v%0d_srcA", i), 64'(bus.srcA), 64'(vecs[i].s_a));
         check($sformatf("v%0d_srcB", i), 64'(bus.srcB), 64'(vecs[i].s_b));
         check($sformatf("v%0d_dstE", i), 64'(bus.dstE), 64'(vecs[i].d_e));
         check($sformatf("v%0d_dstM", i), 64'(bus.dstM), 64'(vecs[i].d_m));
         check($sformatf("v%0d_valA", i), bus.valA, vecs[i].va);
         check($sformatf("v%0d_valB", i), bus.valB, vecs[i].vb);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_dbg", i), bus.dbg_data, vecs[i].dbg_val);
         check($sformatf("v%0d_stat", i), 64'(bus.stat), 64'(vecs[i].st));
      end
      drive(4'h1, 4'hF, 4'hF, 0, 1, 0, 0, 0, 64'h0, 64'h0);
      do_reset();
      check("halt_rst_stat", 64'(bus.stat), 64'd1);
      peek("rst_reg4", 4'h4, 64'h200);
      peek("rst_reg2", 4'h2, 64'h0);
      drive(4'h3, 4'hF, 4'h5, 0, 1, 0, 0, 1, 64'h7, 64'h0);
      peek("no_fwd_dbg", 4'h5, 64'h0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      peek("rst_over_wb", 4'h5, 64'h0);
      drive(4'h3, 4'hF, 4'h5, 0, 0, 0, 0, 1, 64'h7, 64'h0);
      @(posedge clk);
      #1 check("ins_stat", 64'(bus.stat), 64'd4);
      peek("ins_nowrite", 4'h5, 64'h0);
      drive(4'h3, 4'hF, 4'h5, 0, 1, 0, 0, 1, 64'h8, 64'h0);
      @(posedge clk);
      #1 check("ins_sticky", 64'(bus.stat), 64'd4);
      peek("ins_frozen", 4'h5, 64'h0);
      do_reset();
      drive(4'h3, 4'hF, 4'h5, 0, 1, 1, 1, 1, 64'h7, 64'h0);
      @(posedge clk);
      #1 check("adr_stat", 64'(bus.stat), 64'd3);
      peek("adr_nowrite", 4'h5, 64'h0);
      do_reset();
      drive(4'h0, 4'hF, 4'hF, 0, 0, 0, 1, 1, 64'h0, 64'h0);
      @(posedge clk);
      #1 check("ins_over_dmem", 64'(bus.stat), 64'd4);
      do_reset();
      drive(4'hB, 4'h6, 4'hF, 0, 1, 0, 1, 1, 64'h210, 64'h9);
      @(posedge clk);
      #1 check("dmem_stat", 64'(bus.stat), 64'd3);
      peek("dmem_nowrite_m", 4'h6, 64'h0);
      peek("dmem_nowrite_e", 4'h4, 64'h200);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
